// File: rtl/cplx_alu_seq_if.sv
// ---------------------------------------------------------------------------
// cplx_alu_seq_if
//
// Bundles every non-clock/reset signal of cplx_alu_seq so the sequencer and
// its environment share one connection point.
//
// Signals (direction seen from the sequencer, i.e. the slave modport):
//   in_valid   in   1   operand request valid
//   in_ready   out  1   request accepted when in_valid && in_ready at clk edge
//   in_a/in_b  in   10  complex operands, [9:5] real, [4:0] imag,
//                       each part sign-magnitude (bit 4 sign, 3:0 magnitude)
//   in_op      in   2   0 = add, 1 = multiply, 2/3 illegal
//   alu_d1/d2  out  10  registered operands into the downstream complex ALU
//   alu_sel    out  2   registered operation select into the ALU
//   alu_o      in   10  ALU result, same format as in_a
//   out_valid  out  1   result available
//   out_ready  in   1   consumer accepts the result
//   out_data   out  10  captured result
//   out_err    out  1   result came from an illegal in_op
//   done_count out  8   completed output handshakes, saturating at 255
//
// Modports:
//   slave  - the sequencer (cplx_alu_seq)
//   master - the requester / consumer / ALU model driving the sequencer
// ---------------------------------------------------------------------------
interface cplx_alu_seq_if;

  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_a;
  logic [9:0] in_b;
  logic [1:0] in_op;

  logic [9:0] alu_d1;
  logic [9:0] alu_d2;
  logic [1:0] alu_sel;
  logic [9:0] alu_o;

  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_data;
  logic       out_err;
  logic [7:0] done_count;

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  in_op,
    input  alu_o,
    input  out_ready,
    output in_ready,
    output alu_d1,
    output alu_d2,
    output alu_sel,
    output out_valid,
    output out_data,
    output out_err,
    output done_count
  );

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output in_op,
    output alu_o,
    output out_ready,
    input  in_ready,
    input  alu_d1,
    input  alu_d2,
    input  alu_sel,
    input  out_valid,
    input  out_data,
    input  out_err,
    input  done_count
  );

endinterface

// File: rtl/cplx_alu_seq.sv
// ---------------------------------------------------------------------------
// cplx_alu_seq
//
// Sequencer for an external combinational complex ALU. A request is accepted
// in IDLE; legal ops (add/multiply) register the operands and op select into
// the ALU, wait SETTLE_CYCLES edges for the result to settle, capture alu_o
// and present it on a valid/ready output. Illegal ops bypass the ALU and
// immediately present a zero result flagged with out_err.
//
// Ports:
//   clk  in  1  rising-edge clock for all state
//   rst  in  1  synchronous active-high reset
//   bus  cplx_alu_seq_if.slave  request, ALU and result signals (see the
//        interface file for the per-signal description)
//
// Parameters:
//   SETTLE_CYCLES  1..15, default 2: clk edges the ALU inputs are held
//                  before alu_o is sampled; out_valid rises that many edges
//                  after the accept edge.
//
// Build option:
//   CPLX_SEQ_NEGZERO_FIX_EN  when defined, each captured real/imag part with
//                            zero magnitude has its sign cleared (-0 -> +0).
//                            Undefined: alu_o is captured bit-exact.
// ---------------------------------------------------------------------------
module cplx_alu_seq #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic           clk,
  input logic           rst,
  cplx_alu_seq_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);
  localparam logic [7:0] DONE_MAX    = 8'hFF;

  logic [1:0] state_q,     state_d;
  logic [3:0] cnt_q,       cnt_d;
  logic [9:0] alu_d1_q,    alu_d1_d;
  logic [9:0] alu_d2_q,    alu_d2_d;
  logic [1:0] alu_sel_q,   alu_sel_d;
  logic       out_valid_q, out_valid_d;
  logic [9:0] out_data_q,  out_data_d;
  logic       out_err_q,   out_err_d;
  logic [7:0] done_cnt_q,  done_cnt_d;

  logic       op_legal;
  logic [9:0] capture_val;

  // Ops 2 and 3 are the illegal encodings, both have bit 1 set.
  assign op_legal = ~bus.in_op[1];

`ifdef CPLX_SEQ_NEGZERO_FIX_EN
  logic [4:0] cap_re;
  logic [4:0] cap_im;

  // Clear the sign of any part whose magnitude is zero.
  always_comb begin
    cap_re = bus.alu_o[9:5];
    cap_im = bus.alu_o[4:0];
    if (cap_re[3:0] == 4'd0) begin
      cap_re[4] = 1'b0;
    end
    if (cap_im[3:0] == 4'd0) begin
      cap_im[4] = 1'b0;
    end
    capture_val = {cap_re, cap_im};
  end
`else
  assign capture_val = bus.alu_o;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_d1_d    = alu_d1_q;
    alu_d2_d    = alu_d2_q;
    alu_sel_d   = alu_sel_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    done_cnt_d  = done_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (op_legal) begin
            alu_d1_d  = bus.in_a;
            alu_d2_d  = bus.in_b;
            alu_sel_d = bus.in_op;
            cnt_d     = SETTLE_INIT;
            state_d   = ST_WAIT;
          end else begin
            // ALU registers are left untouched for an illegal request.
            out_data_d  = '0;
            out_err_d   = 1'b1;
            out_valid_d = 1'b1;
            state_d     = ST_HOLD;
          end
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // <= rather than == so a zero count can never strand the FSM here;
        // for any legal SETTLE_CYCLES the count reaches exactly 1.
        if (cnt_q <= 4'd1) begin
          cnt_d       = '0;
          out_data_d  = capture_val;
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
          if (done_cnt_q != DONE_MAX) begin
            done_cnt_d = done_cnt_q + 8'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      alu_d1_q    <= '0;
      alu_d2_q    <= '0;
      alu_sel_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_d1_q    <= alu_d1_d;
      alu_d2_q    <= alu_d2_d;
      alu_sel_q   <= alu_sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  // Only IDLE accepts, so the accept and output handshakes are never on the
  // same edge.
  assign bus.in_ready   = (state_q == ST_IDLE) && !rst;
  assign bus.alu_d1     = alu_d1_q;
  assign bus.alu_d2     = alu_d2_q;
  assign bus.alu_sel    = alu_sel_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_err    = out_err_q;
  assign bus.done_count = done_cnt_q;

endmodule

// File: tb/tb_cplx_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_cplx_alu_seq
//
// Directed self-checking bench for cplx_alu_seq with SETTLE_CYCLES = 2.
// Inputs are driven 1 time unit after a rising edge and outputs are sampled
// at the same point, well away from the active edge. The ALU result is
// driven directly by the bench with the hand-computed value for each op.
// ---------------------------------------------------------------------------
module tb_cplx_alu_seq;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  cplx_alu_seq_if bus ();

  cplx_alu_seq #(.SETTLE_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 10; i++) begin
      bus.in_valid  = 1'($urandom);
      bus.in_a      = 10'($urandom);
      bus.in_b      = 10'($urandom);
      bus.in_op     = 2'($urandom);
      bus.out_ready = 1'($urandom);
      bus.alu_o     = 10'($urandom);
      step();
    end
    rst = 1'b1;
    step();
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_in_ready_low got %b exp 0", bus.in_ready);
    end
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid);
    end
    n_cmp++;
    if (bus.out_data !== 10'h000) begin
      n_err++; $display("FAIL reset_out_data got %h exp 000", bus.out_data);
    end
    n_cmp++;
    if (bus.alu_sel !== 2'd0) begin
      n_err++; $display("FAIL reset_alu_sel got %0d exp 0", bus.alu_sel);
    end
    n_cmp++;
    if (bus.done_count !== 8'd0) begin
      n_err++; $display("FAIL reset_done_count got %0d exp 0", bus.done_count);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_in_ready_held got %b exp 0", bus.in_ready);
    end
    idle_inputs();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready_after got %b exp 1", bus.in_ready);
    end
  endtask

  // (3+2i) + (1-i) = 4+i
  task automatic test_add();
    bus.alu_o    = 10'h081;
    bus.in_a     = 10'h062;
    bus.in_b     = 10'h031;
    bus.in_op    = 2'd0;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.alu_d1 !== 10'h062) begin
      n_err++; $display("FAIL add_alu_d1 got %h exp 062", bus.alu_d1);
    end
    n_cmp++;
    if (bus.alu_d2 !== 10'h031) begin
      n_err++; $display("FAIL add_alu_d2 got %h exp 031", bus.alu_d2);
    end
    n_cmp++;
    if (bus.alu_sel !== 2'd0) begin
      n_err++; $display("FAIL add_alu_sel got %0d exp 0", bus.alu_sel);
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL add_valid_edge1 got %b exp 0", bus.out_valid);
    end
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL add_valid_edge2 got %b exp 0", bus.out_valid);
    end
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin
      n_err++; $display("FAIL add_valid_rise got %b exp 1", bus.out_valid);
    end
    n_cmp++;
    if (bus.out_data !== 10'h081) begin
      n_err++; $display("FAIL add_out_data got %h exp 081", bus.out_data);
    end
    n_cmp++;
    if (bus.out_err !== 1'b0) begin
      n_err++; $display("FAIL add_out_err got %b exp 0", bus.out_err);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL add_valid_fall got %b exp 0", bus.out_valid);
    end
    n_cmp++;
    if (bus.done_count !== 8'd1) begin
      n_err++; $display("FAIL add_done_count got %0d exp 1", bus.done_count);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL add_back_idle got %b exp 1", bus.in_ready);
    end
  endtask

  // (3+2i) * (1-i) = 5-i, held under 5 cycles of backpressure
  task automatic test_mul_backpressure();
    bus.alu_o    = 10'h0B1;
    bus.in_a     = 10'h062;
    bus.in_b     = 10'h031;
    bus.in_op    = 2'd1;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin
      n_err++; $display("FAIL mul_valid_rise got %b exp 1", bus.out_valid);
    end
    // Scramble alu_o and offer a competing request while stalled.
    bus.alu_o    = 10'h3FF;
    bus.in_a     = 10'h155;
    bus.in_b     = 10'h2AA;
    bus.in_op    = 2'd0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (bus.out_data !== 10'h0B1 || bus.out_valid !== 1'b1) begin
        n_err++; $display("FAIL mul_hold cyc %0d got data %h valid %b exp 0b1/1", i, bus.out_data, bus.out_valid);
      end
      n_cmp++;
      if (bus.in_ready !== 1'b0) begin
        n_err++; $display("FAIL mul_in_ready cyc %0d got %b exp 0", i, bus.in_ready);
      end
      n_cmp++;
      if (bus.alu_d1 !== 10'h062 || bus.alu_d2 !== 10'h031 || bus.alu_sel !== 2'd1) begin
        n_err++; $display("FAIL mul_alu_regs cyc %0d got %h %h %0d exp 062 031 1", i, bus.alu_d1, bus.alu_d2, bus.alu_sel);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    n_cmp++;
    if (bus.done_count !== 8'd2 || bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL mul_handshake got cnt %0d valid %b exp 2/0", bus.done_count, bus.out_valid);
    end
  endtask

  task automatic test_illegal();
    bus.alu_o    = 10'h3FF;
    bus.in_a     = 10'h123;
    bus.in_b     = 10'h321;
    bus.in_op    = 2'd2;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin
      n_err++; $display("FAIL ill_valid got %b exp 1", bus.out_valid);
    end
    n_cmp++;
    if (bus.out_data !== 10'h000) begin
      n_err++; $display("FAIL ill_out_data got %h exp 000", bus.out_data);
    end
    n_cmp++;
    if (bus.out_err !== 1'b1) begin
      n_err++; $display("FAIL ill_out_err got %b exp 1", bus.out_err);
    end
    n_cmp++;
    if (bus.alu_sel !== 2'd1 || bus.alu_d1 !== 10'h062) begin
      n_err++; $display("FAIL ill_alu_regs got sel %0d d1 %h exp 1/062", bus.alu_sel, bus.alu_d1);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    n_cmp++;
    if (bus.done_count !== 8'd3) begin
      n_err++; $display("FAIL ill_done_count got %0d exp 3", bus.done_count);
    end
  endtask

  task automatic negzero_case(input logic [9:0] alu_val, input logic [9:0] exp_val);
    bus.alu_o    = alu_val;
    bus.in_a     = 10'h001;
    bus.in_b     = 10'h002;
    bus.in_op    = 2'd0;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    n_cmp++;
    if (bus.out_data !== exp_val || bus.out_err !== 1'b0) begin
      n_err++; $display("FAIL negzero alu_o %h got %h err %b exp %h err 0", alu_val, bus.out_data, bus.out_err, exp_val);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_negzero();
`ifdef CPLX_SEQ_NEGZERO_FIX_EN
    negzero_case(10'h200, 10'h000);
    negzero_case(10'h230, 10'h220);
`else
    negzero_case(10'h200, 10'h200);
    negzero_case(10'h230, 10'h230);
`endif
    negzero_case(10'h2A5, 10'h2A5);
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    bus.alu_o    = 10'h081;
    bus.in_a     = 10'h062;
    bus.in_b     = 10'h031;
    bus.in_op    = 2'd0;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL midrst_idle got %b exp 1", bus.in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
        n_err++; $display("FAIL midrst_no_valid cyc %0d got %b exp 0", i, bus.out_valid);
      end
      step();
    end
    n_cmp++;
    if (bus.done_count !== 8'd0) begin
      n_err++; $display("FAIL midrst_done_count got %0d exp 0", bus.done_count);
    end
  endtask

  // Each illegal request with both handshakes held high takes 2 edges.
  task automatic test_saturation();
    do_reset();
    bus.in_op     = 2'd3;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 508; i++) step();
    n_cmp++;
    if (bus.done_count !== 8'd254) begin
      n_err++; $display("FAIL sat_254 got %0d exp 254", bus.done_count);
    end
    step();
    step();
    n_cmp++;
    if (bus.done_count !== 8'd255) begin
      n_err++; $display("FAIL sat_255 got %0d exp 255", bus.done_count);
    end
    step();
    step();
    n_cmp++;
    if (bus.done_count !== 8'd255) begin
      n_err++; $display("FAIL sat_hold got %0d exp 255", bus.done_count);
    end
    idle_inputs();
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    idle_inputs();
    bus.alu_o = '0;
    step();
    step();
    rst = 1'b0;
    step();

    test_reset();
    test_add();
    test_mul_backpressure();
    test_illegal();
    test_negzero();
    test_reset_mid_op();
    test_saturation();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cplx_alu_seq.md
CPLX_ALU_SEQ -- requirements
Module: cplx_alu_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 Parameter SETTLE_CYCLES SHALL default to 2, be 1..15, and give the number of clk edges the ALU inputs are held before alu_o is sampled.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 in_valid  in  1  operand request valid.
REQ-006 in_ready  out  1  request accepted when in_valid and in_ready are both high at a clk edge.
REQ-007 in_a, in_b  in  10 each  complex operands: [9:5] real part, [4:0] imaginary part; each part is sign-magnitude (bit 4 sign, bits 3:0 magnitude).
REQ-008 in_op  in  2  operation code: 0 = add, 1 = multiply, 2 and 3 illegal.
REQ-009 alu_d1, alu_d2  out  10 each  registered operands driven into the downstream complex ALU.
REQ-010 alu_sel  out  2  registered operation select driven into the ALU.
REQ-011 alu_o  in  10  ALU result, same format as in_a.
REQ-012 out_valid  out  1  result available.
REQ-013 out_ready  in  1  consumer accepts the result.
REQ-014 out_data  out  10  captured result.
REQ-015 out_err  out  1  the result came from an illegal in_op.
REQ-016 done_count  out  8  count of completed output handshakes.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT and HOLD.
REQ-018 in_ready SHALL be high only in IDLE with rst low.
REQ-019 A legal accept in IDLE SHALL, at that edge:
- load alu_d1 = in_a, alu_d2 = in_b, alu_sel = in_op;
- load the settle counter with SETTLE_CYCLES;
- enter WAIT.
REQ-020 In WAIT the counter SHALL decrement on each edge.
REQ-021 On the edge where the counter equals 1, the block SHALL capture alu_o into out_data, set out_err = 0, set out_valid = 1 and enter HOLD; out_valid therefore rises SETTLE_CYCLES edges after the accept edge.
REQ-022 An illegal-op accept SHALL, at that edge:
- leave alu_d1, alu_d2 and alu_sel unchanged;
- set out_data = 0, out_err = 1, out_valid = 1;
- enter HOLD.
REQ-023 alu_d1, alu_d2 and alu_sel SHALL change only on a legal accept edge and stay stable at all other times.
REQ-024 In HOLD, out_data, out_err and out_valid SHALL stay stable until an edge with out_ready high; on that edge out_valid falls, the FSM enters IDLE and done_count increments, saturating at 255.
REQ-025 in_valid outside IDLE SHALL be ignored, with no state change.
REQ-026 out_ready outside HOLD SHALL be ignored.
REQ-027 in_ready stays low during the output-handshake edge, so accept and output handshakes never occur on the same edge.

Reset
REQ-028 While rst is high at an edge, all of the following SHALL be 0: state (IDLE), counter, alu_d1, alu_d2, alu_sel, out_valid, out_data, out_err, done_count.
REQ-029 Reset in WAIT or HOLD SHALL abort the transaction with no out_valid pulse and no done_count increment.
REQ-030 in_ready SHALL be 0 while rst is high and 1 on the first cycle after rst falls.

Configuration
REQ-031 The macro CPLX_SEQ_NEGZERO_FIX_EN SHALL control negative-zero handling on capture:
- defined: each captured part with magnitude 0 gets its sign cleared (-0 becomes +0);
- undefined: alu_o is captured bit-exact.
REQ-032 The macro SHALL have no effect on the illegal-op result, timing, or any other output.

Verification
REQ-033 Reset: rst high for 2 edges after random activity -> out_valid = 0, out_data = 0x000, alu_sel = 0, done_count = 0; in_ready = 0 during reset and 1 on the next cycle.
REQ-034 Add, SETTLE_CYCLES = 2: in_a = 0x062 (3+2i), in_b = 0x031 (1-i), in_op = 0, model alu_o = 0x081 -> after the accept edge alu_d1 = 0x062, alu_d2 = 0x031, alu_sel = 0; out_valid rises 2 edges after accept with out_data = 0x081, out_err = 0; done_count = 1 after the handshake.
REQ-035 Multiply with backpressure: in_op = 1, same operands, alu_o = 0x0B1 (5-i), out_ready low for 5 cycles -> out_data held at 0x0B1, in_ready = 0, a concurrent in_valid is ignored, alu_d1 and alu_d2 unchanged.
REQ-036 Illegal op: in_op = 2 -> out_valid on the accept edge with out_data = 0x000, out_err = 1; alu_sel keeps its previous value.
REQ-037 Reset mid-operation: rst asserted one edge into WAIT -> state IDLE, no out_valid pulse, done_count unchanged at 0.
REQ-038 Macro check: alu_o = 0x200 (real -0, imag +0) -> out_data = 0x000 with CPLX_SEQ_NEGZERO_FIX_EN defined, 0x200 without; 256 completed transactions -> done_count saturates at 255.
